// File: rtl/adaptive_sampling_pkg.sv
// Shared types for the adaptive sampling chain.
//   state_e       : scheduler FSM states
//   div_t         : 16-bit sample-clock divider value
//   DivMaxDefault : reset / no-signal divider
package adaptive_sampling_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMeasure,
    StCheck,
    StCompute,
    StUpdate
  } state_e;

  typedef logic [15:0] div_t;

  localparam div_t DivMaxDefault = 16'hFFFF;

endpackage

// File: rtl/window_timer.sv
// Measurement window counter.
//   clk_i   : system clock
//   reset_i : asynchronous active-high reset
//   clear_i : hold counter at zero (scheduler idle)
//   tc_o    : one-cycle terminal-count pulse, once every WindowCycles cycles
module window_timer #(
  parameter int unsigned WindowCycles = 65536
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tc_o
);

  localparam int unsigned CntW = (WindowCycles > 1) ? $clog2(WindowCycles) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WindowCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tc_q, tc_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == LastCnt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Registered pulse: high for exactly the cycle the counter sits at its last value.
    tc_d = !clear_i && (cnt_d == LastCnt);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/adaptive_rate_scheduler.sv
// Samples two channel periods once per window, picks the shortest non-zero one,
// qualifies it for stability and pushes a clamped divider over a req/ack handshake.
//   clk_i, reset_i (async, active-high), enable_i
//   period_a_i, period_b_i : channel periods in clk cycles, 0 = no signal
//   div_out_o, div_req_o, div_ack_i : divider update handshake
//   channel_sel_o (0 = A, 1 = B), locked_o, no_signal_o
module adaptive_rate_scheduler
  import adaptive_sampling_pkg::*;
#(
  parameter int unsigned WindowCycles = 65536,
  parameter int unsigned StableCount  = 4,
  parameter int unsigned TolShift     = 4,
  parameter int unsigned SppLog2      = 6,
  parameter int unsigned DivMin       = 1,
  parameter int unsigned DivMax       = 32'(DivMaxDefault)
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [31:0] period_a_i,
  input  logic [31:0] period_b_i,
  output logic [15:0] div_out_o,
  output logic        div_req_o,
  input  logic        div_ack_i,
  output logic        channel_sel_o,
  output logic        locked_o,
  output logic        no_signal_o
);

  localparam logic [3:0] StableMax = 4'(StableCount);

  state_e      state_q, state_d;
  logic [31:0] pa_q, pa_d, pb_q, pb_d;
  logic [31:0] prev_p_q, prev_p_d;
  logic [3:0]  stable_q, stable_d;
  div_t        div_q, div_d;
  logic        req_q, req_d;
  logic        sel_q, sel_d;
  logic        locked_q, locked_d;
  logic        nosig_q, nosig_d;
  logic        tc;

  window_timer #(
    .WindowCycles(WindowCycles)
  ) u_window_timer (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(state_q == StIdle),
    .tc_o   (tc)
  );

  // Governing period: shortest non-zero channel, ties go to A.
  logic        a_nz, b_nz, sel_b;
  logic [31:0] p_cur;
  logic [32:0] diff, tol;
  logic        in_tol;

  assign a_nz   = (pa_q != '0);
  assign b_nz   = (pb_q != '0);
  assign sel_b  = b_nz && (!a_nz || (pb_q < pa_q));
  assign p_cur  = sel_b ? pb_q : pa_q;
  assign diff   = (p_cur >= prev_p_q) ? ({1'b0, p_cur} - {1'b0, prev_p_q})
                                      : ({1'b0, prev_p_q} - {1'b0, p_cur});
  assign tol    = {1'b0, prev_p_q >> TolShift};
  assign in_tol = (diff <= tol);

  // Divider from the period registered in CHECK (prev_p_q holds it during COMPUTE).
  logic [31:0] d_raw, d_clamp;
  div_t        div_new;

  always_comb begin
    d_raw = prev_p_q >> SppLog2;
    if (d_raw < DivMin) begin
      d_clamp = DivMin;
    end else if (d_raw > DivMax) begin
      d_clamp = DivMax;
    end else begin
      d_clamp = d_raw;
    end
    div_new = div_t'(d_clamp);
  end

  always_comb begin
    state_d  = state_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    prev_p_d = prev_p_q;
    stable_d = stable_q;
    div_d    = div_q;
    req_d    = req_q;
    sel_d    = sel_q;
    locked_d = locked_q;
    nosig_d  = nosig_q;

    unique case (state_q)
      StIdle: begin
        stable_d = '0;
        locked_d = 1'b0;
        if (enable_i) state_d = StMeasure;
      end
      StMeasure: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (tc) begin
          pa_d    = period_a_i;
          pb_d    = period_b_i;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (!a_nz && !b_nz) begin
          nosig_d  = 1'b1;
          stable_d = '0;
          locked_d = 1'b0;
          prev_p_d = '0;
          sel_d    = 1'b0;
          state_d  = StMeasure;
        end else begin
          nosig_d  = 1'b0;
          sel_d    = sel_b;
          prev_p_d = p_cur;
          if (in_tol) begin
            if (stable_q < StableMax) stable_d = stable_q + 1'b1;
          end else begin
            stable_d = 4'd1;
            locked_d = 1'b0;
          end
          state_d = (stable_d == StableMax) ? StCompute : StMeasure;
        end
      end
      StCompute: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (div_new != div_q) begin
          div_d   = div_new;
          req_d   = 1'b1;
          state_d = StUpdate;
        end else begin
          locked_d = 1'b1;
          state_d  = StMeasure;
        end
      end
      StUpdate: begin
        // Handshake always completes before honouring a dropped enable.
        if (div_ack_i) begin
          req_d    = 1'b0;
          locked_d = 1'b1;
          state_d  = enable_i ? StMeasure : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      pa_q     <= '0;
      pb_q     <= '0;
      prev_p_q <= '0;
      stable_q <= '0;
      div_q    <= div_t'(DivMax);
      req_q    <= 1'b0;
      sel_q    <= 1'b0;
      locked_q <= 1'b0;
      nosig_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      prev_p_q <= prev_p_d;
      stable_q <= stable_d;
      div_q    <= div_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      locked_q <= locked_d;
      nosig_q  <= nosig_d;
    end
  end

  assign div_out_o     = div_q;
  assign div_req_o     = req_q;
  assign channel_sel_o = sel_q;
  assign locked_o      = locked_q;
  assign no_signal_o   = nosig_q;

endmodule
